// File: rtl/rv_pkg.sv
// Scoreboard constants shared with the decoder that produces id_lat_i.
package rv_pkg;

    localparam int NREG  = 32;
    localparam int CNT_W = 4;
    localparam int IDX_W = $clog2(NREG);

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t LAT_ALU  = cnt_t'(0);
    localparam cnt_t LAT_LOAD = cnt_t'(1);
    localparam cnt_t LAT_MUL  = cnt_t'(3);
    localparam cnt_t LAT_VAR  = cnt_t'((1 << CNT_W) - 1);

    function automatic logic cnt_pending(input cnt_t c);
        return c != LAT_ALU;
    endfunction

endpackage

// File: rtl/rv_sb_entry.sv
// One scoreboard countdown: issue overrides done, done overrides decrement.
module rv_sb_entry
    import rv_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             issue_i,
    input  logic [CNT_W-1:0] lat_i,
    input  logic             done_i,
    output logic [CNT_W-1:0] cnt_o
);

    cnt_t cnt_q;
    cnt_t cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (issue_i) begin
            cnt_d = lat_i;
        end else if (cnt_q == LAT_VAR) begin
            // Unbounded entries only leave via completion of their own unit.
            if (done_i) begin
                cnt_d = LAT_ALU;
            end
        end else if (cnt_pending(cnt_q)) begin
            cnt_d = cnt_q - cnt_t'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= LAT_ALU;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/rv_scoreboard.sv
// Producer-side hazard tracker: stalls ID while a source register's value
// is still further away than the MEM/WB forwarding paths.
module rv_scoreboard
    import rv_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             id_valid_i,
    input  logic [IDX_W-1:0] id_rs1_i,
    input  logic [IDX_W-1:0] id_rs2_i,
    input  logic             id_rs1_used_i,
    input  logic             id_rs2_used_i,
    input  logic             id_rd_we_i,
    input  logic [IDX_W-1:0] id_rd_i,
    input  logic [CNT_W-1:0] id_lat_i,
    input  logic             flush_i,
    input  logic             done_valid_i,
    input  logic [IDX_W-1:0] done_rd_i,
    output logic             stall_o,
    output logic [NREG-1:0]  pending_o,
    output logic             busy_o
);

    logic [NREG-1:0][CNT_W-1:0] cnt;
    logic                       haz1;
    logic                       haz2;
    logic                       issue;

    assign cnt[0] = '0;

    for (genvar r = 1; r < NREG; r++) begin : g_entry
        rv_sb_entry u_entry (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .issue_i (issue && (id_rd_i == IDX_W'(r))),
            .lat_i   (id_lat_i),
            .done_i  (done_valid_i && (done_rd_i == IDX_W'(r))),
            .cnt_o   (cnt[r])
        );
    end

    // Hazards look at the count before this cycle's issue, so rs==rd never self-stalls.
    always_comb begin
        haz1    = id_rs1_used_i && cnt_pending(cnt[id_rs1_i]);
        haz2    = id_rs2_used_i && cnt_pending(cnt[id_rs2_i]);
        stall_o = id_valid_i && !flush_i && (haz1 || haz2);
        issue   = id_valid_i && !stall_o && !flush_i && id_rd_we_i && (id_rd_i != '0);
    end

    always_comb begin
        pending_o = '0;
        for (int r = 0; r < NREG; r++) begin
            pending_o[r] = cnt_pending(cnt[r]);
        end
        busy_o = |pending_o;
    end

endmodule

// File: tb/tb_rv_scoreboard.sv
// Bench for rv_scoreboard: directed pipeline scenarios plus random traffic,
// checked against a model that tracks the cycle each register becomes forwardable.
module tb_rv_scoreboard;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        id_valid_i;
    logic [4:0]  id_rs1_i, id_rs2_i, id_rd_i, done_rd_i;
    logic        id_rs1_used_i, id_rs2_used_i, id_rd_we_i;
    logic [3:0]  id_lat_i;
    logic        flush_i, done_valid_i;
    logic        stall_o;
    logic [31:0] pending_o;
    logic        busy_o;

    int errs   = 0;
    int checks = 0;

    // Model: register r is forwardable from cycle rdy[r] on, unless unb[r].
    longint cyc;
    longint rdy[32];
    bit     unb[32];

    always #5 clk = ~clk;

    rv_scoreboard dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .id_valid_i    (id_valid_i),
        .id_rs1_i      (id_rs1_i),
        .id_rs2_i      (id_rs2_i),
        .id_rs1_used_i (id_rs1_used_i),
        .id_rs2_used_i (id_rs2_used_i),
        .id_rd_we_i    (id_rd_we_i),
        .id_rd_i       (id_rd_i),
        .id_lat_i      (id_lat_i),
        .flush_i       (flush_i),
        .done_valid_i  (done_valid_i),
        .done_rd_i     (done_rd_i),
        .stall_o       (stall_o),
        .pending_o     (pending_o),
        .busy_o        (busy_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic bit m_pend(input int r);
        return (r != 0) && (unb[r] || cyc < rdy[r]);
    endfunction

    task automatic model_clear();
        for (int r = 0; r < 32; r++) begin
            rdy[r] = 0;
            unb[r] = 1'b0;
        end
    endtask

    // One ID cycle: drive, check combinational/registered outputs, advance the model.
    task automatic step(input bit v, input bit [4:0] rs1, input bit [4:0] rs2,
                        input bit u1, input bit u2, input bit we, input bit [4:0] rd,
                        input bit [3:0] lat, input bit fl, input bit dv,
                        input bit [4:0] drd, input bit rs, output bit st);
        bit          exp_st;
        bit          iss;
        logic [31:0] exp_pend;
        @(negedge clk);
        id_valid_i = v; id_rs1_i = rs1; id_rs2_i = rs2;
        id_rs1_used_i = u1; id_rs2_used_i = u2; id_rd_we_i = we;
        id_rd_i = rd; id_lat_i = lat; flush_i = fl;
        done_valid_i = dv; done_rd_i = drd; rst_i = rs;
        #1;
        for (int r = 0; r < 32; r++) exp_pend[r] = m_pend(r);
        exp_st = v && !fl && ((u1 && m_pend(rs1)) || (u2 && m_pend(rs2)));
        check("stall", {31'b0, stall_o}, {31'b0, exp_st});
        check("pending", pending_o, exp_pend);
        check("busy", {31'b0, busy_o}, {31'b0, |exp_pend});
        st = stall_o;
        @(posedge clk);
        iss = v && !exp_st && !fl && we && (rd != 0);
        if (rs) begin
            model_clear();
        end else begin
            if (dv && unb[drd]) begin
                unb[drd] = 1'b0;
                rdy[drd] = cyc + 1;
            end
            if (iss) begin
                unb[rd] = (lat == 4'd15);
                rdy[rd] = cyc + 1 + lat;
            end
        end
        cyc++;
    endtask

    task automatic idle(output bit st);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, st);
    endtask

    // Producer issue with no sources.
    task automatic prod(input bit [4:0] rd, input bit [3:0] lat);
        bit st;
        step(1, 0, 0, 0, 0, 1, rd, lat, 0, 0, 0, 0, st);
    endtask

    // Hold an ALU dependant of rs in ID until it issues; count its stall cycles.
    task automatic dep_count(input bit [4:0] rs, output int n);
        bit st;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            step(1, rs, 5'd1, 1, 1, 1, 5'd6, 4'd0, 0, 0, 0, 0, st);
            if (!st) return;
            n++;
        end
        check("dep_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        bit st;
        int n;
        rst_i = 1'b1; id_valid_i = 0; id_rs1_i = 0; id_rs2_i = 0;
        id_rs1_used_i = 0; id_rs2_used_i = 0; id_rd_we_i = 0; id_rd_i = 0;
        id_lat_i = 0; flush_i = 0; done_valid_i = 0; done_rd_i = 0;
        repeat (2) @(posedge clk);
        cyc = 0;
        model_clear();
        idle(st);
        check("reset_pending", pending_o, 32'd0);

        // Load-use: one bubble.
        prod(5'd5, 4'd1);
        step(1, 5'd5, 5'd1, 1, 1, 1, 5'd6, 4'd0, 0, 0, 0, 0, st);
        check("lu_stall", {31'b0, st}, 32'd1);
        step(1, 5'd5, 5'd1, 1, 1, 1, 5'd6, 4'd0, 0, 0, 0, 0, st);
        check("lu_go", {31'b0, st}, 32'd0);

        // ALU chain never stalls.
        prod(5'd5, 4'd0);
        step(1, 5'd5, 5'd5, 1, 1, 1, 5'd7, 4'd0, 0, 0, 0, 0, st);
        check("alu_chain", {31'b0, st}, 32'd0);

        // Multiply: three stall cycles.
        prod(5'd8, 4'd3);
        dep_count(5'd8, n);
        check("mul_stalls", n, 32'd3);

        // Divide: held 20 cycles, then done, released the cycle after.
        prod(5'd9, 4'd15);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            step(1, 5'd9, 5'd1, 1, 1, 1, 5'd6, 4'd0, 0, 0, 0, 0, st);
            n += st;
        end
        step(1, 5'd9, 5'd1, 1, 1, 1, 5'd6, 4'd0, 0, 1, 5'd9, 0, st);
        n += st;
        check("div_stalls", n, 32'd21);
        step(1, 5'd9, 5'd1, 1, 1, 1, 5'd6, 4'd0, 0, 0, 0, 0, st);
        check("div_release", {31'b0, st}, 32'd0);

        // WAW: ALU write clears pending divide; stray done ignored.
        prod(5'd9, 4'd15);
        prod(5'd9, 4'd0);
        step(1, 5'd9, 5'd1, 1, 1, 1, 5'd6, 4'd0, 0, 0, 0, 0, st);
        check("waw_clear", {31'b0, st}, 32'd0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'd9, 0, st);
        check("late_done", pending_o, 32'd0);
        // Issue and done on x9 together: issue value survives.
        prod(5'd9, 4'd15);
        step(1, 5'd0, 5'd0, 0, 0, 1, 5'd9, 4'd2, 0, 1, 5'd9, 0, st);
        dep_count(5'd9, n);
        check("collide_stalls", n, 32'd2);

        // Filters: unused rs2, x0 write, flush.
        prod(5'd5, 4'd3);
        step(1, 5'd3, 5'd5, 1, 0, 1, 5'd4, 4'd0, 0, 0, 0, 0, st);
        check("rs2_unused", {31'b0, st}, 32'd0);
        repeat (3) idle(st);
        prod(5'd0, 4'd1);
        check("x0_write", pending_o, 32'd0);
        prod(5'd10, 4'd15);
        step(1, 5'd10, 5'd0, 1, 0, 1, 5'd11, 4'd3, 1, 0, 0, 0, st);
        check("flush_nostall", {31'b0, st}, 32'd0);
        idle(st);
        check("flush_noissue", {31'b0, pending_o[11]}, 32'd0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'd10, 0, st);

        // Reset mid-operation.
        prod(5'd9, 4'd15);
        prod(5'd5, 4'd2);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, st);
        step(1, 5'd9, 5'd5, 1, 1, 0, 0, 0, 0, 0, 0, 0, st);
        check("rst_stall", {31'b0, st}, 32'd0);
        check("rst_busy", {31'b0, busy_o}, 32'd0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'd9, 0, st);

        // Random traffic on a small register window to provoke collisions.
        for (int i = 0; i < 3000; i++) begin
            bit [3:0] lat;
            case ($urandom_range(0, 5))
                0: lat = 4'd0;
                1: lat = 4'd1;
                2: lat = 4'd3;
                3: lat = 4'd15;
                default: lat = 4'($urandom_range(0, 15));
            endcase
            step($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom_range(0, 7)), lat,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0,
                 5'($urandom_range(0, 7)), $urandom_range(0, 199) == 0, st);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
